// File: rtl/i2c_txn_arbiter_pkg.sv
// i2c_arb_pkg: shared definitions for the I2C transaction arbiter.
//   arb_state_t : sequencer states (ARB, LAUNCH, RUN, FIN)
//   CTL_IDLE    : controller state-bus value meaning "no transfer in flight"
//   ADDR_W      : I2C slave address width
//   DATA_W      : I2C data byte width
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_FIN    = 2'd3
    } arb_state_t;

    localparam logic [2:0] CTL_IDLE = 3'b000;
    localparam int         ADDR_W   = 7;
    localparam int         DATA_W   = 8;

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// i2c_txn_arbiter_if: requester-side and controller-side signals of the
// I2C transaction arbiter, bundled as one interface.
//   Requester side : req, req_addr, req_wdata, req_rw (to arbiter)
//                    gnt, done, rdata, err (from arbiter)
//   Controller side: ctl_start, ctl_addr, ctl_data_in, ctl_r_w_en, ctl_reset
//                    (from arbiter), ctl_state, ctl_rdata (to arbiter)
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters plus controller)
interface i2c_txn_arbiter_if #(
    parameter int N_REQ = 4
);
    import i2c_arb_pkg::*;

    logic [N_REQ-1:0]        req;
    logic [ADDR_W*N_REQ-1:0] req_addr;
    logic [DATA_W*N_REQ-1:0] req_wdata;
    logic [N_REQ-1:0]        req_rw;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic [DATA_W-1:0]       rdata;
    logic                    err;

    logic                    ctl_start;
    logic [ADDR_W-1:0]       ctl_addr;
    logic [DATA_W-1:0]       ctl_data_in;
    logic                    ctl_r_w_en;
    logic [2:0]              ctl_state;
    logic [DATA_W-1:0]       ctl_rdata;
    logic                    ctl_reset;

    modport slave (
        input  req, req_addr, req_wdata, req_rw, ctl_state, ctl_rdata,
        output gnt, done, rdata, err,
               ctl_start, ctl_addr, ctl_data_in, ctl_r_w_en, ctl_reset
    );

    modport master (
        output req, req_addr, req_wdata, req_rw, ctl_state, ctl_rdata,
        input  gnt, done, rdata, err,
               ctl_start, ctl_addr, ctl_data_in, ctl_r_w_en, ctl_reset
    );

endinterface

// File: rtl/i2c_txn_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req     in  N_REQ         : pending requests
//   last    in  clog2(N_REQ)  : index served most recently
//   win     out N_REQ         : one-hot winner (all zero when req is zero)
//   win_idx out clog2(N_REQ)  : index of the winner
// The search starts one past 'last' and wraps; the first pending index wins.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic [N_REQ-1:0]         win,
    output logic [$clog2(N_REQ)-1:0] win_idx
);
    localparam int IDX_W = $clog2(N_REQ);

    logic             found;
    logic [IDX_W-1:0] pos;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        pos     = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            pos = IDX_W'((int'(last) + off) % N_REQ);
            if (!found && req[pos]) begin
                found    = 1'b1;
                win[pos] = 1'b1;
                win_idx  = pos;
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: shares one I2C controller between N_REQ requesters.
// A round-robin winner's address, write byte and direction are latched into
// the controller pins, the controller is started, and its state bus is
// tracked until it returns to idle. The winner then gets a one-cycle done
// strobe and, for reads, the returned byte on rdata.
// Ports:
//   clk   in : system clock (rising edge)
//   reset in : asynchronous active-low reset
//   bus      : i2c_txn_arbiter_if.slave (requester and controller signals)
// Parameters:
//   N_REQ       : number of requesters, 2..8
//   TIMEOUT_CYC : watchdog limit in clk cycles (timeout build only)
// Build option:
//   I2C_ARB_TIMEOUT_EN - adds a 16-bit watchdog over LAUNCH/RUN that aborts
//   the controller (ctl_reset low for one cycle) and completes with err=1.
//   Without it ctl_reset is tied 1, err tied 0 and transfers wait forever.
module i2c_txn_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              reset,
    i2c_txn_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("i2c_txn_arbiter: N_REQ must be in 2..8");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("i2c_txn_arbiter: TIMEOUT_CYC must fit the 16-bit watchdog");
    end

    arb_state_t        state;
    logic [IDX_W-1:0]  last;
    logic [N_REQ-1:0]  gnt_r;
    logic [N_REQ-1:0]  done_r;
    logic              start_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              rw_r;
    logic [DATA_W-1:0] rdata_r;

    logic [N_REQ-1:0]  win;
    logic [IDX_W-1:0]  win_idx;

`ifdef I2C_ARB_TIMEOUT_EN
    logic              err_r;
    logic              ctl_reset_r;
    logic [15:0]       tmo_cnt;
`endif

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req     (bus.req),
        .last    (last),
        .win     (win),
        .win_idx (win_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_ARB;
            last    <= IDX_W'(N_REQ - 1);
            gnt_r   <= '0;
            done_r  <= '0;
            start_r <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            rw_r    <= 1'b0;
            rdata_r <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            err_r       <= 1'b0;
            ctl_reset_r <= 1'b1;
            tmo_cnt     <= '0;
`endif
        end else begin
            done_r <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            err_r       <= 1'b0;
            ctl_reset_r <= 1'b1;
`endif
            unique case (state)
                ST_ARB: begin
                    if (|bus.req) begin
                        gnt_r   <= win;
                        last    <= win_idx;
                        addr_r  <= bus.req_addr[win_idx*ADDR_W +: ADDR_W];
                        wdata_r <= bus.req_wdata[win_idx*DATA_W +: DATA_W];
                        rw_r    <= bus.req_rw[win_idx];
                        start_r <= 1'b1;
                        state   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    // Hold start until the controller shows it has left idle.
                    if (bus.ctl_state != CTL_IDLE) begin
                        start_r <= 1'b0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.ctl_state == CTL_IDLE) begin
                        if (rw_r) begin
                            rdata_r <= bus.ctl_rdata;
                        end
                        done_r <= gnt_r;
                        state  <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    // done is already high this cycle; release the grant.
                    gnt_r <= '0;
                    state <= ST_ARB;
                end
                default: state <= ST_ARB;
            endcase
`ifdef I2C_ARB_TIMEOUT_EN
            // Watchdog overrides the normal LAUNCH/RUN decisions above.
            if (state == ST_LAUNCH || state == ST_RUN) begin
                tmo_cnt <= tmo_cnt + 16'd1;
                if (tmo_cnt == 16'(TIMEOUT_CYC)) begin
                    start_r     <= 1'b0;
                    rdata_r     <= rdata_r;
                    ctl_reset_r <= 1'b0;
                    err_r       <= 1'b1;
                    done_r      <= gnt_r;
                    state       <= ST_FIN;
                end
            end else if (state == ST_ARB) begin
                tmo_cnt <= '0;
            end
`endif
        end
    end

    assign bus.gnt         = gnt_r;
    assign bus.done        = done_r;
    assign bus.rdata       = rdata_r;
    assign bus.ctl_start   = start_r;
    assign bus.ctl_addr    = addr_r;
    assign bus.ctl_data_in = wdata_r;
    assign bus.ctl_r_w_en  = rw_r;
`ifdef I2C_ARB_TIMEOUT_EN
    assign bus.err         = err_r;
    assign bus.ctl_reset   = ctl_reset_r;
`else
    assign bus.err         = 1'b0;
    assign bus.ctl_reset   = 1'b1;
`endif

endmodule

// File: doc/i2c_txn_arbiter.md
# i2c_txn_arbiter

Round-robin arbiter and sequencer that shares one I2C controller between `N_REQ` requesters. It captures a requester's address, write byte and direction, then starts the controller and tracks its state bus until the transfer ends. It then returns the read byte and a one-cycle completion strobe to the winning requester. It sits directly above the I2C controller and drives that controller's `start`, `addr`, `data_in` and `r_w_en` pins.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYC`, default 4096: watchdog limit in clk cycles; used only with the macro.
- `clk` in 1: single system clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in N_REQ: per-requester level request; the requester holds it until its `done` bit.
- `req_addr` in 7*N_REQ: packed 7-bit slave addresses; slice i belongs to requester i.
- `req_wdata` in 8*N_REQ: packed write bytes.
- `req_rw` in N_REQ: 1 = read, 0 = write, matching controller `r_w_en`.
- `gnt` out N_REQ: one-hot, high from grant to completion.
- `done` out N_REQ: one-hot, one-cycle completion pulse.
- `rdata` out 8: read byte, valid in the `done` cycle and held until the next `done`.
- `err` out 1: high in the `done` cycle when the transfer timed out.
- `ctl_start` out 1: drives controller `start`.
- `ctl_addr` out 7: drives controller `addr`.
- `ctl_data_in` out 8: drives controller `data_in`.
- `ctl_r_w_en` out 1: drives controller `r_w_en`.
- `ctl_state` in 3: controller `STATE_reg`; 3'b000 = idle.
- `ctl_rdata` in 8: controller `reg_temp_1`.
- `ctl_reset` out 1: active-low abort to the controller.

## Operation
- FSM states:
  - ARB: pick a requester; on any `req`, move to LAUNCH.
  - LAUNCH: `ctl_start`=1; when `ctl_state`≠0, move to RUN.
  - RUN: `ctl_start`=0; when `ctl_state`==0, move to FIN.
  - FIN: pulse `done`, clear `gnt`, move to ARB.
- Arbitration is round-robin. The search starts at index `last+1` mod N_REQ, where `last` is the index most recently served. It starts at 0 after reset. The lowest index at or after the start position wins.
- On the ARB→LAUNCH edge the arbiter latches the winner's `req_addr`, `req_wdata` and `req_rw` into the `ctl_*` registers. These stay stable until FIN, so requester inputs may change after grant.
- Deasserting `req` while granted is ignored; the transfer completes and `done` still pulses.
- `rdata` captures `ctl_rdata` on the RUN→FIN transition, for reads only. On writes it holds its previous value.
- Reset values: `gnt`, `done`, `err`, `ctl_start`, `ctl_addr`, `ctl_data_in`, `ctl_r_w_en` and `rdata` are 0. `ctl_reset`=1, the FSM is in ARB and `last`=N_REQ-1.
- Reset mid-transfer: all registers return to reset values immediately. No `done` is issued for the aborted transfer.

## Timing
- `req` seen in ARB at edge k → `gnt` and `ctl_start` high after edge k. Grant latency is 1 cycle.
- `ctl_start` stays high until the first edge that samples `ctl_state`≠0, then drops on that edge.
- `done` is high for exactly the cycle after the edge where RUN sees `ctl_state`==0.
- ARB is always visited for at least one cycle between transfers, so there is one idle cycle between back-to-back grants.
- A `req` arriving during a transfer waits; no request is lost.

## Configuration
- With `I2C_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter runs in LAUNCH and RUN.
  - When the counter reaches `TIMEOUT_CYC`, `ctl_reset` is driven 0 for one cycle and the FSM goes to FIN with `err`=1. `rdata` is unchanged.
  - The counter clears in ARB.
- Without `I2C_ARB_TIMEOUT_EN`:
  - There is no counter.
  - `ctl_reset` is constant 1 and `err` is constant 0.
  - LAUNCH and RUN wait indefinitely.

## Structure
- Package `i2c_arb_pkg` holds:
  - FSM state encoding: ARB, LAUNCH, RUN, FIN.
  - `CTL_IDLE` = 3'b000.
  - Width constants 7 (address) and 8 (data).
- Sub-module `rr_pick` is a combinational round-robin picker with inputs `req` and `last` and outputs a one-hot winner and its index. It is instantiated once.

## Test plan
- Single write: `req[1]`=1, addr 7'h47, wdata 8'hB4, rw 0, model walks `ctl_state` 0→1→…→0. Required: `ctl_addr`=7'h47, `ctl_data_in`=8'hB4, `gnt`=4'b0010, one `done[1]` pulse, `err`=0.
- Read: `req[2]`=1, rw 1, addr 7'h73, model returns `ctl_rdata`=8'hC9. Required: `rdata`=8'hC9 in the `done[2]` cycle, held afterwards.
- Contention: `req`=4'b1111 held from reset. Required grant order 0,1,2,3,0, with one idle cycle between `done` and the next `gnt`.
- Reset mid-RUN: drop `reset` while `gnt[3]` is high. Required: all outputs 0 (`ctl_reset` 1) immediately, no `done[3]`; after release the first grant goes to the lowest pending index.
- Timeout (`I2C_ARB_TIMEOUT_EN`, TIMEOUT_CYC=16): model holds `ctl_state`=3 forever. Required: `ctl_reset` low for 1 cycle, `done[0]`=1 with `err`=1, and `rdata` unchanged.
